cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbiter and burst sequencer that shares the single pipelined main memory between the I-cache fill FSM, the D-cache fill FSM and the D-cache write-through path. It grants the memory to one requester at a time and, for a fill, generates the eight 2-byte reads of a 16-byte block. It then counts the returning words and steers `mem_data_valid` to the owning cache. It sits between both cache controllers and the memory model.

## Interface
- `BURST_LEN`, 8: words per cache block. Power of two, at most 8.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `i_fill_req` in 1: I-cache miss pending. Level signal, held until `i_grant` falls.
- `i_fill_addr` in 16: I-cache miss address.
- `d_fill_req` in 1: D-cache miss pending. Level signal, held until `d_grant` falls.
- `d_fill_addr` in 16: D-cache miss address.
- `d_wr_req` in 1: D-cache write-through request. Level signal, held until `d_wr_ack`.
- `d_wr_addr` in 16: write address.
- `d_wr_data` in 16: write data.
- `d_wr_ack` out 1: one-cycle pulse in the cycle the write is issued.
- `i_grant` out 1: memory owned by the I-fill. This is the I-side stall qualifier.
- `d_grant` out 1: memory owned by the D-fill.
- `i_data_valid` out 1: `mem_data_valid` steered to the I-cache.
- `d_data_valid` out 1: `mem_data_valid` steered to the D-cache.
- `fill_data` out 16: copy of `mem_data_out`, broadcast to both caches.
- `mem_enable` out 1: memory request strobe.
- `mem_wr` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: memory address.
- `mem_data_in` out 16: memory write data.
- `mem_data_out` in 16: memory read data.
- `mem_data_valid` in 1: read data valid. The memory accepts one request per cycle and returns reads in order after a fixed latency of at least 1 cycle.

## Operation
- States are IDLE, FILL_I, FILL_D and WRITE. State bits use a 2-bit register.
- Reset: all registers clear asynchronously. State goes to IDLE and both counters go to 0.
- Reset values of every output: `mem_enable`, `mem_wr`, `d_wr_ack`, `i_grant`, `d_grant`, `i_data_valid` and `d_data_valid` are 0. `mem_addr` and `mem_data_in` are 16'h0000.
- Arbitration happens only in IDLE. Priority is `d_wr_req` > `d_fill_req` > `i_fill_req`, unless changed by the Configuration section.
- IDLE→WRITE latches `d_wr_addr` and `d_wr_data`.
- IDLE→FILL_x latches base = `x_fill_addr & 16'hFFF0` and clears `issue_cnt` and `ret_cnt`.
- In WRITE, for exactly 1 cycle: `mem_enable`=1, `mem_wr`=1, latched address and data on the bus, `d_wr_ack`=1. The next state is IDLE.
- In FILL_x, while `issue_cnt` < `BURST_LEN`:
  - `mem_enable`=1, `mem_wr`=0.
  - `mem_addr` = base + 2*`issue_cnt`, a 16-bit add. Wrap-around at 16'hFFFE is discarded.
  - `issue_cnt` increments once per cycle.
- In FILL_x, `x_data_valid` = `mem_data_valid`. Each valid increments `ret_cnt`.
- When `ret_cnt` == `BURST_LEN`-1 and `mem_data_valid`=1, the next state is IDLE.
- `x_grant` = (state == FILL_x). It is decoded from registered state only.
- A `mem_data_valid` arriving in IDLE or WRITE is dropped. Neither valid output asserts.
- A request deasserted mid-fill does not abort the burst. The burst always completes.
- Counters are 4 bits wide and never exceed `BURST_LEN`.

## Timing
- Request sampled high in IDLE at edge N:
  - Grant is high from cycle N+1.
  - The first read is issued in cycle N+1 and the last in cycle N+`BURST_LEN`.
- With memory latency L, data returns in cycles N+1+L through N+`BURST_LEN`+L.
- Grant falls in the cycle after the last valid. That cycle is IDLE, and a new grant can be issued on the following edge.
- A write costs 2 cycles from request to completion: IDLE sample, then WRITE.
- If a D write and a D fill request simultaneously, the write goes first. The fill is granted after the return to IDLE.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: fill priority alternates.
  - A 1-bit `last_fill` register records the most recently granted fill and resets to I.
  - When both fill requests are pending, the side not in `last_fill` wins.
  - Writes keep top priority.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority D-fill > I-fill, with no `last_fill` register.

## Test plan
- I-fill alone:
  - Stimulus: `i_fill_req`=1, `i_fill_addr`=16'h1236, memory latency 4.
  - Required: `mem_addr` 16'h1230, 1232, …, 123E on 8 consecutive cycles.
  - Required: 8 `i_data_valid` pulses, `d_data_valid` stays 0, `i_grant` drops one cycle after the 8th valid.
- Simultaneous fills:
  - Stimulus: I and D fill requests rise on the same edge, addresses 16'h0040 and 16'h8000.
  - Required without the macro: the D burst runs first, then the I burst. The I-fill is granted exactly 1 idle cycle after D completes.
  - Required with the macro: after reset the D burst runs first. With both requests held for a second round, the I burst is granted next.
- Write during a fill:
  - Stimulus: `d_wr_req` asserted mid I-burst with addr 16'h2000, data 16'hBEEF.
  - Required: `d_wr_ack`=0 until the burst completes. Then a 1-cycle write with `mem_wr`=1, 16'h2000 and 16'hBEEF on the bus, and `d_wr_ack`=1.
- Address wrap:
  - Stimulus: fill at 16'hFFF4.
  - Required: addresses 16'hFFF0 through 16'hFFFE only. No carry into the next block.
- Reset mid-burst:
  - Stimulus: drop `rst_n` after the 3rd valid. Release reset while stale valids still arrive.
  - Required: all outputs are 0 immediately. The stale valids are dropped. A new request is granted normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Memory arbiter and burst sequencer shared by the I-fill, D-fill and D write-through paths.
// Build option: define ARB_ROUND_ROBIN_EN to alternate priority between the two fill requesters.
module cache_mem_arbiter #(
  parameter int BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fill_req,
  input  logic [15:0] i_fill_addr,
  input  logic        d_fill_req,
  input  logic [15:0] d_fill_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_ack,
  output logic        i_grant,
  output logic        d_grant,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [15:0] fill_data,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid
);

  // Handshake: requests are levels. A fill request stays high until its grant falls,
  // a write request until d_wr_ack pulses. New work is accepted only in IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } state_t;

  localparam logic [3:0] BURST = 4'(BURST_LEN);
  localparam logic [3:0] LAST  = 4'(BURST_LEN - 1);

  state_t      state;
  logic [3:0]  issue_cnt;
  logic [3:0]  ret_cnt;
  logic [15:0] base;
  logic        pick_d;
  logic [15:0] fill_base;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_fill;  // 1 = D-fill was granted most recently
  assign pick_d = d_fill_req && (!i_fill_req || !last_fill);
`else
  assign pick_d = d_fill_req;
`endif

  assign fill_base = (pick_d ? d_fill_addr : i_fill_addr) & 16'hFFF0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_cnt   <= 4'd0;
      ret_cnt     <= 4'd0;
      base        <= 16'h0000;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_data_in <= 16'h0000;
      d_wr_ack    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_fill   <= 1'b0;
`endif
    end else begin
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_data_in <= 16'h0000;
      d_wr_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            state       <= WRITE;
            mem_enable  <= 1'b1;
            mem_wr      <= 1'b1;
            mem_addr    <= d_wr_addr;
            mem_data_in <= d_wr_data;
            d_wr_ack    <= 1'b1;
          end else if (d_fill_req || i_fill_req) begin
            // Word 0 goes out in the first granted cycle, so issue_cnt starts at 1.
            state      <= pick_d ? FILL_D : FILL_I;
            base       <= fill_base;
            mem_enable <= 1'b1;
            mem_addr   <= fill_base;
            issue_cnt  <= 4'd1;
            ret_cnt    <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_fill  <= pick_d;
`endif
          end
        end
        WRITE: state <= IDLE;
        FILL_I, FILL_D: begin
          if (issue_cnt < BURST) begin
            mem_enable <= 1'b1;
            mem_addr   <= base + {11'd0, issue_cnt, 1'b0};
            issue_cnt  <= issue_cnt + 4'd1;
          end
          if (mem_data_valid) begin
            if (ret_cnt == LAST) begin
              state   <= IDLE;
              ret_cnt <= 4'd0;
            end else begin
              ret_cnt <= ret_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Steering qualified by registered state only; valids outside a fill are dropped.
  assign i_grant      = (state == FILL_I);
  assign d_grant      = (state == FILL_D);
  assign i_data_valid = i_grant & mem_data_valid;
  assign d_data_valid = d_grant & mem_data_valid;
  assign fill_data    = mem_data_out;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: latency-configurable memory model, per-cycle output log,
// and a transaction-level schedule model for randomized request mixes.
module tb_cache_mem_arbiter;
  localparam int B = 8;
  localparam int N = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_fill_req = 1'b0, d_fill_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_fill_addr = 16'h0, d_fill_addr = 16'h0, d_wr_addr = 16'h0, d_wr_data = 16'h0;
  logic        d_wr_ack, i_grant, d_grant, i_data_valid, d_data_valid, mem_enable, mem_wr;
  logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
  logic        mem_data_valid;

  int errors = 0;
  int checks = 0;
  int cyc;
  int lat = 1;
  logic i_seen = 1'b0, d_seen = 1'b0;
  logic rr_last = 1'b0;

  logic        rv[N];
  logic [15:0] rd[N];
  logic        lg_en[N], lg_wr[N], lg_ack[N], lg_ig[N], lg_dg[N], lg_iv[N], lg_dv[N];
  logic [15:0] lg_addr[N], lg_din[N], lg_fd[N];
  logic        e_en[N], e_wr[N], e_ack[N], e_ig[N], e_dg[N], e_iv[N], e_dv[N];
  logic [15:0] e_addr[N], e_din[N];
  logic [15:0] exp_q[$];

  cache_mem_arbiter #(.BURST_LEN(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_fill_req(i_fill_req), .i_fill_addr(i_fill_addr),
    .d_fill_req(d_fill_req), .d_fill_addr(d_fill_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack), .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid), .fill_data(fill_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory model: reads accepted once per cycle, returned in order after `lat` cycles.
  initial begin
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    cyc = 0;
    mem_data_valid = 1'b0;
    mem_data_out = 16'h0;
    forever begin
      @(posedge clk); #1;
      cyc = cyc + 1;
      mem_data_valid = rv[cyc % N];
      mem_data_out = rv[cyc % N] ? rd[cyc % N] : 16'h0;
      rv[cyc % N] = 1'b0;
      @(negedge clk);
      lg_en[cyc % N] = mem_enable;  lg_wr[cyc % N] = mem_wr;   lg_ack[cyc % N] = d_wr_ack;
      lg_ig[cyc % N] = i_grant;     lg_dg[cyc % N] = d_grant;
      lg_iv[cyc % N] = i_data_valid; lg_dv[cyc % N] = d_data_valid;
      lg_addr[cyc % N] = mem_addr;  lg_din[cyc % N] = mem_data_in; lg_fd[cyc % N] = fill_data;
      if (mem_enable && !mem_wr) begin
        rv[(cyc + lat) % N] = 1'b1;
        rd[(cyc + lat) % N] = mem_word(mem_addr);
      end
    end
  end

  // driver tasks: one cycle step with cache-side request protocol
  task automatic step();
    @(negedge clk); #1;
    if (i_grant) i_seen = 1'b1;
    else if (i_seen) begin i_fill_req = 1'b0; i_seen = 1'b0; end
    if (d_grant) d_seen = 1'b1;
    else if (d_seen) begin d_fill_req = 1'b0; d_seen = 1'b0; end
    if (d_wr_ack) d_wr_req = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_enable, mem_wr, d_wr_ack, i_grant, d_grant, i_data_valid, d_data_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 0000000",
               {mem_enable, mem_wr, d_wr_ack, i_grant, d_grant, i_data_valid, d_data_valid});
    end
    checks++;
    if (mem_addr !== 16'h0000 || mem_data_in !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h data=%h, want 0000 0000", mem_addr, mem_data_in);
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({mem_enable, i_grant, d_grant} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got en/ig/dg=%b, want 000", {mem_enable, i_grant, d_grant});
    end
  endtask

  task automatic test_i_fill();
    int c, g, nv;
    logic exp_v;
    lat = 4;
    step();
    c = cyc; i_fill_req = 1'b1; i_fill_addr = 16'h1236;
    g = c + 1;
    run_to(g + B + lat);
    for (int k = 0; k < B; k++) begin
      checks++;
      if ({lg_en[g+k], lg_wr[g+k], lg_addr[g+k]} !== {1'b1, 1'b0, 16'h1230 + 16'(2*k)}) begin
        errors++;
        $display("FAIL ifill_issue[%0d]: got en=%b wr=%b addr=%h, want en=1 wr=0 addr=%h",
                 k, lg_en[g+k], lg_wr[g+k], lg_addr[g+k], 16'h1230 + 16'(2*k));
      end
    end
    checks++;
    if (lg_en[g+B] !== 1'b0) begin
      errors++; $display("FAIL ifill_extra_issue: got en=%b, want 0", lg_en[g+B]);
    end
    nv = 0;
    for (int j = c; j <= g + B + lat; j++) begin
      exp_v = (j >= g + lat) && (j < g + lat + B);
      checks++;
      if (lg_iv[j] !== exp_v || lg_dv[j] !== 1'b0 ||
          (exp_v && lg_fd[j] !== mem_word(16'h1230 + 16'(2*(j-g-lat))))) begin
        errors++;
        $display("FAIL ifill_valid@%0d: got iv=%b dv=%b data=%h, want iv=%b dv=0",
                 j - c, lg_iv[j], lg_dv[j], lg_fd[j], exp_v);
      end
      if (lg_iv[j] === 1'b1) nv++;
    end
    checks++;
    if (nv != B) begin errors++; $display("FAIL ifill_count: got %0d, want %0d", nv, B); end
    checks++;
    if ({lg_ig[c], lg_ig[g], lg_ig[g+B+lat-1], lg_ig[g+B+lat]} !== 4'b0110) begin
      errors++;
      $display("FAIL ifill_grant_window: got %b, want 0110",
               {lg_ig[c], lg_ig[g], lg_ig[g+B+lat-1], lg_ig[g+B+lat]});
    end
    repeat (3) step();
  endtask

  task automatic test_simultaneous();
    int c, g1, e1, g2, g3, ni, nd;
    logic sec_d;
    lat = $urandom_range(1, 6);
    repeat (2) step();
    c = cyc;
    i_fill_req = 1'b1; i_fill_addr = 16'h0040;
    d_fill_req = 1'b1; d_fill_addr = 16'h8000;
    g1 = c + 1; e1 = g1 + B + lat; g2 = e1 + 1;
    run_to(g2 + B + lat);
    checks++;
    if ({lg_dg[g1], lg_ig[g1], lg_addr[g1]} !== {2'b10, 16'h8000}) begin
      errors++;
      $display("FAIL simul_first: got dg=%b ig=%b addr=%h, want dg=1 ig=0 addr=8000",
               lg_dg[g1], lg_ig[g1], lg_addr[g1]);
    end
    checks++;
    if ({lg_dg[e1-1], lg_dg[e1], lg_ig[e1], lg_ig[g2]} !== 4'b1001) begin
      errors++;
      $display("FAIL simul_gap: got dg(last)/dg(idle)/ig(idle)/ig(next)=%b, want 1001",
               {lg_dg[e1-1], lg_dg[e1], lg_ig[e1], lg_ig[g2]});
    end
    checks++;
    if (lg_addr[g2] !== 16'h0040) begin
      errors++; $display("FAIL simul_i_addr: got %h, want 0040", lg_addr[g2]);
    end
    ni = 0; nd = 0;
    for (int j = c; j <= g2 + B + lat; j++) begin
      if (lg_iv[j] === 1'b1) ni++;
      if (lg_dv[j] === 1'b1) nd++;
    end
    checks++;
    if (ni != B || nd != B) begin
      errors++; $display("FAIL simul_counts: got i=%0d d=%0d, want %0d each", ni, nd, B);
    end
    // Second round: D re-requests in the idle slot while I is still waiting.
    repeat (2) step();
    c = cyc;
    i_fill_req = 1'b1; i_fill_addr = 16'h0050;
    d_fill_req = 1'b1; d_fill_addr = 16'h8010;
    e1 = c + 1 + B + lat;
    run_to(e1);
    d_fill_req = 1'b1; d_fill_addr = 16'h8020;
    g2 = e1 + 1; g3 = g2 + B + lat + 1;
`ifdef ARB_ROUND_ROBIN_EN
    sec_d = 1'b0;
`else
    sec_d = 1'b1;
`endif
    run_to(g3 + B + lat);
    checks++;
    if (lg_dg[c+1] !== 1'b1) begin
      errors++; $display("FAIL round2_first: got dg=%b, want 1", lg_dg[c+1]);
    end
    checks++;
    if ({lg_dg[g2], lg_ig[g2], lg_addr[g2]} !== {sec_d, !sec_d, sec_d ? 16'h8020 : 16'h0050}) begin
      errors++;
      $display("FAIL round2_second: got dg=%b ig=%b addr=%h, want dg=%b", lg_dg[g2], lg_ig[g2],
               lg_addr[g2], sec_d);
    end
    checks++;
    if ({lg_dg[g3], lg_ig[g3], lg_addr[g3]} !== {!sec_d, sec_d, sec_d ? 16'h0050 : 16'h8020}) begin
      errors++;
      $display("FAIL round2_third: got dg=%b ig=%b addr=%h, want dg=%b", lg_dg[g3], lg_ig[g3],
               lg_addr[g3], !sec_d);
    end
    repeat (3) step();
  endtask

  task automatic test_write_during_fill();
    int c, g, e, w0, ni;
    lat = 3;
    step();
    c = cyc; i_fill_req = 1'b1; i_fill_addr = 16'h3008;
    g = c + 1; e = g + B + lat;
    run_to(g + 2);
    w0 = cyc; d_wr_req = 1'b1; d_wr_addr = 16'h2000; d_wr_data = 16'hBEEF;
    run_to(e + 2);
    ni = 0;
    for (int j = w0; j <= e; j++) begin
      checks++;
      if (lg_ack[j] !== 1'b0 || lg_wr[j] !== 1'b0) begin
        errors++; $display("FAIL early_write@%0d: got ack=%b wr=%b, want 0 0", j - w0, lg_ack[j], lg_wr[j]);
      end
      if (lg_iv[j] === 1'b1) ni++;
    end
    for (int j = c; j < w0; j++) if (lg_iv[j] === 1'b1) ni++;
    checks++;
    if (ni != B) begin errors++; $display("FAIL wr_burst_count: got %0d, want %0d", ni, B); end
    checks++;
    if ({lg_ack[e+1], lg_en[e+1], lg_wr[e+1], lg_addr[e+1], lg_din[e+1]} !== {3'b111, 16'h2000, 16'hBEEF}) begin
      errors++;
      $display("FAIL write_cycle: got ack=%b en=%b wr=%b addr=%h data=%h, want 1 1 1 2000 BEEF",
               lg_ack[e+1], lg_en[e+1], lg_wr[e+1], lg_addr[e+1], lg_din[e+1]);
    end
    checks++;
    if ({lg_ack[e+2], lg_en[e+2]} !== 2'b00) begin
      errors++; $display("FAIL write_one_cycle: got ack=%b en=%b, want 0 0", lg_ack[e+2], lg_en[e+2]);
    end
    repeat (3) step();
  endtask

  task automatic test_wrap();
    int c, g, nd;
    lat = 2;
    step();
    c = cyc; d_fill_req = 1'b1; d_fill_addr = 16'hFFF4;
    g = c + 1;
    run_to(g + B + lat);
    for (int k = 0; k < B; k++) begin
      checks++;
      if ({lg_en[g+k], lg_addr[g+k]} !== {1'b1, 16'hFFF0 + 16'(2*k)}) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got en=%b addr=%h, want en=1 addr=%h", k, lg_en[g+k],
                 lg_addr[g+k], 16'hFFF0 + 16'(2*k));
      end
    end
    nd = 0;
    for (int j = g; j <= g + B + lat; j++) if (lg_dv[j] === 1'b1) nd++;
    checks++;
    if (nd != B || lg_en[g+B] !== 1'b0 || lg_dg[g+B+lat] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: got valids=%0d en=%b dg=%b, want %0d 0 0", nd, lg_en[g+B],
               lg_dg[g+B+lat], B);
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid_burst();
    int c, g, r, c2, g2, nd;
    lat = 5;
    step();
    c = cyc; i_fill_req = 1'b1; i_fill_addr = 16'h4440;
    g = c + 1;
    run_to(g + lat + 2);
    checks++;
    if (lg_iv[g+lat+2] !== 1'b1) begin
      errors++; $display("FAIL third_valid: got %b, want 1", lg_iv[g+lat+2]);
    end
    rst_n = 1'b0;
    i_fill_req = 1'b0;
    #1;
    checks++;
    if ({mem_enable, mem_wr, d_wr_ack, i_grant, d_grant, i_data_valid, d_data_valid} !== 7'b0 ||
        mem_addr !== 16'h0 || mem_data_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_immediate: got ctrl=%b addr=%h data=%h, want 0",
               {mem_enable, mem_wr, d_wr_ack, i_grant, d_grant, i_data_valid, d_data_valid},
               mem_addr, mem_data_in);
    end
    repeat (2) step();
    rst_n = 1'b1;
    r = cyc + 1;
    run_to(g + lat + B);
    for (int j = r; j <= g + lat + B; j++) begin
      checks++;
      if ({lg_iv[j], lg_dv[j], lg_ig[j], lg_dg[j], lg_en[j]} !== 5'b0) begin
        errors++;
        $display("FAIL stale_valid@%0d: got iv/dv/ig/dg/en=%b, want 00000", j - r,
                 {lg_iv[j], lg_dv[j], lg_ig[j], lg_dg[j], lg_en[j]});
      end
    end
    step();
    c2 = cyc; d_fill_req = 1'b1; d_fill_addr = 16'h0104;
    g2 = c2 + 1;
    run_to(g2 + B + lat);
    nd = 0;
    for (int j = g2; j < g2 + B + lat; j++)
      if (lg_dv[j] === 1'b1 && lg_fd[j] === mem_word(16'h0100 + 16'(2*(j-g2-lat)))) nd++;
    checks++;
    if ({lg_dg[g2], lg_addr[g2], lg_dg[g2+B+lat]} !== {1'b1, 16'h0100, 1'b0} || nd != B) begin
      errors++;
      $display("FAIL post_reset_fill: got dg=%b addr=%h good_valids=%0d, want 1 0100 %0d",
               lg_dg[g2], lg_addr[g2], nd, B);
    end
    repeat (3) step();
  endtask

  task automatic test_random();
    int c, t, last;
    logic [2:0] sel;
    logic pw, pd, pi, side_d;
    logic [15:0] ia, da, wa, wd, base, got;
    rst_n = 1'b0;
    i_fill_req = 1'b0; d_fill_req = 1'b0; d_wr_req = 1'b0; i_seen = 1'b0; d_seen = 1'b0;
    step();
    rst_n = 1'b1;
    rr_last = 1'b0;
    exp_q.delete();
    for (int it = 0; it < 30; it++) begin
      lat = $urandom_range(1, 6);
      sel = 3'($urandom_range(1, 7));
      ia = 16'($urandom); da = 16'($urandom); wa = 16'($urandom); wd = 16'($urandom);
      repeat (2) step();
      c = cyc;
      if (sel[2]) begin d_wr_req = 1'b1; d_wr_addr = wa; d_wr_data = wd; end
      if (sel[1]) begin d_fill_req = 1'b1; d_fill_addr = da; end
      if (sel[0]) begin i_fill_req = 1'b1; i_fill_addr = ia; end
      for (int j = c; j < c + 80; j++) begin
        e_en[j] = 0; e_wr[j] = 0; e_ack[j] = 0; e_ig[j] = 0; e_dg[j] = 0; e_iv[j] = 0; e_dv[j] = 0;
        e_addr[j] = 16'h0; e_din[j] = 16'h0;
      end
      // Transaction-level schedule: write first, then fills in arbitration order.
      pw = sel[2]; pd = sel[1]; pi = sel[0];
      t = c + 1;
      while (pw || pd || pi) begin
        if (pw) begin
          e_en[t] = 1; e_wr[t] = 1; e_ack[t] = 1; e_addr[t] = wa; e_din[t] = wd;
          t = t + 2; pw = 0;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
          side_d = (pd && pi) ? !rr_last : pd;
`else
          side_d = pd;
`endif
          rr_last = side_d;
          base = (side_d ? da : ia) & 16'hFFF0;
          for (int k = 0; k < B; k++) begin
            e_en[t+k] = 1; e_addr[t+k] = base + 16'(2*k);
            if (side_d) e_dv[t+lat+k] = 1; else e_iv[t+lat+k] = 1;
            exp_q.push_back(mem_word(base + 16'(2*k)));
          end
          for (int k = 0; k < B + lat; k++) begin
            if (side_d) e_dg[t+k] = 1; else e_ig[t+k] = 1;
          end
          if (side_d) pd = 0; else pi = 0;
          t = t + B + lat + 1;
        end
      end
      last = t - 1;
      run_to(last);
      for (int j = c + 1; j <= last; j++) begin
        checks++;
        if ({lg_en[j], lg_wr[j], lg_ack[j], lg_ig[j], lg_dg[j], lg_iv[j], lg_dv[j]} !==
            {e_en[j], e_wr[j], e_ack[j], e_ig[j], e_dg[j], e_iv[j], e_dv[j]} ||
            (e_en[j] && lg_addr[j] !== e_addr[j]) || (e_wr[j] && lg_din[j] !== e_din[j])) begin
          errors++;
          $display("FAIL rand%0d@%0d: got ctrl=%b addr=%h din=%h, want ctrl=%b addr=%h din=%h",
                   it, j - c, {lg_en[j], lg_wr[j], lg_ack[j], lg_ig[j], lg_dg[j], lg_iv[j], lg_dv[j]},
                   lg_addr[j], lg_din[j], {e_en[j], e_wr[j], e_ack[j], e_ig[j], e_dg[j], e_iv[j], e_dv[j]},
                   e_addr[j], e_din[j]);
        end
        if (lg_iv[j] === 1'b1 || lg_dv[j] === 1'b1) begin
          got = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          checks++;
          if (lg_fd[j] !== got) begin
            errors++; $display("FAIL rand%0d_data@%0d: got %h, want %h", it, j - c, lg_fd[j], got);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_leftover: got %0d words unreturned, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_simultaneous();
    test_write_during_fill();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
